// File: rtl/spu32_cpu_sequencer_pkg.sv
// Shared sequencer defines: RISC-V opcode field values, state encodings,
// PC source selects and trap cause codes.
package spu32_cpu_sequencer_pkg;

  // instr[6:2] opcode field values
  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_MISCMEM = 5'b00011;
  localparam logic [4:0] OP_OPIMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_OP      = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_SYSTEM  = 5'b11100;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [1:0] PCSEL_INC    = 2'd0;
  localparam logic [1:0] PCSEL_TARGET = 2'd1;
  localparam logic [1:0] PCSEL_TRAP   = 2'd2;

  localparam logic [3:0] CAUSE_IFETCH_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_FAULT   = 4'd5;
  localparam logic [3:0] CAUSE_STORE_FAULT  = 4'd7;
  localparam logic [3:0] CAUSE_EXT_IRQ      = 4'd11;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH, OP_LUI,
      OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_MISCMEM: op_legal = 1'b1;
      default:                                         op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spu32_cpu_sequencer_if.sv
// Sequencer <-> datapath control bundle; master is the sequencer side.
interface spu32_cpu_sequencer_if;
  logic [4:0] I_opcode;
  logic       I_bus_ack;
  logic       I_alu_busy;
  logic       I_branch_taken;
  logic       I_irq;
  logic       I_irq_en;
  logic       O_decoder_en;
  logic       O_alu_en;
  logic       O_bus_en;
  logic       O_bus_sel;
  logic       O_reg_we;
  logic       O_pc_we;
  logic [1:0] O_pc_sel;
  logic       O_trap;
  logic       O_trap_irq;
  logic [3:0] O_trap_cause;
  logic [2:0] O_state;

  modport master (
    input  I_opcode, I_bus_ack, I_alu_busy, I_branch_taken, I_irq, I_irq_en,
    output O_decoder_en, O_alu_en, O_bus_en, O_bus_sel, O_reg_we, O_pc_we,
           O_pc_sel, O_trap, O_trap_irq, O_trap_cause, O_state
  );

  modport slave (
    output I_opcode, I_bus_ack, I_alu_busy, I_branch_taken, I_irq, I_irq_en,
    input  O_decoder_en, O_alu_en, O_bus_en, O_bus_sel, O_reg_we, O_pc_we,
           O_pc_sel, O_trap, O_trap_irq, O_trap_cause, O_state
  );
endinterface

// File: rtl/spu32_cpu_bustimer.sv
// Bus request watchdog: counts un-acked cycles, flags the cycle in which
// the BUS_TIMEOUT-th consecutive un-acked cycle occurs.
module spu32_cpu_bustimer #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic ack,
  output logic expired
);

  localparam int W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(BUS_TIMEOUT - 1);

  logic [W-1:0] cnt;

  // an ack landing in the limit cycle wins over the timeout
  assign expired = !clear && !ack && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clear || ack)   cnt <= '0;
    else if (!expired)       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/spu32_cpu_sequencer.sv
// SPU32 multi-cycle control sequencer: fetch/decode/exec/mem/wb with
// illegal-opcode, bus-timeout and external-interrupt traps.
module spu32_cpu_sequencer
  import spu32_cpu_sequencer_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                         I_clk,
  input  logic                         I_reset_n,
  spu32_cpu_sequencer_if.master        bus
);

  logic [2:0] state, state_nxt;
  logic [3:0] cause, cause_nxt;
  logic       trap_irq, trap_irq_nxt;
  logic       alu_first;
  logic       timer_clear, expired;
  logic       is_mem_op;

  assign timer_clear = !(state == ST_FETCH || state == ST_MEM);
  assign is_mem_op   = (bus.I_opcode == OP_LOAD) || (bus.I_opcode == OP_STORE);

  spu32_cpu_bustimer #(.BUS_TIMEOUT(BUS_TIMEOUT)) u_bustimer (
    .clk     (I_clk),
    .rst_n   (I_reset_n),
    .clear   (timer_clear),
    .ack     (bus.I_bus_ack),
    .expired (expired)
  );

  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause;
    trap_irq_nxt = trap_irq;
    case (state)
      ST_RESET: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (bus.I_bus_ack) state_nxt = ST_DECODE;
        else if (expired) begin
          state_nxt    = ST_TRAP;
          cause_nxt    = CAUSE_IFETCH_FAULT;
          trap_irq_nxt = 1'b0;
        end
      end
      ST_DECODE: begin
        if (op_legal(bus.I_opcode)) state_nxt = ST_EXEC;
        else begin
          state_nxt    = ST_TRAP;
          cause_nxt    = CAUSE_ILLEGAL;
          trap_irq_nxt = 1'b0;
        end
      end
      ST_EXEC: if (!bus.I_alu_busy) state_nxt = is_mem_op ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (bus.I_bus_ack) state_nxt = ST_WB;
        else if (expired) begin
          state_nxt    = ST_TRAP;
          cause_nxt    = (bus.I_opcode == OP_STORE) ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
          trap_irq_nxt = 1'b0;
        end
      end
      ST_WB: begin
        // interrupts are only taken at an instruction boundary
        if (bus.I_irq && bus.I_irq_en) begin
          state_nxt    = ST_TRAP;
          cause_nxt    = CAUSE_EXT_IRQ;
          trap_irq_nxt = 1'b1;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_TRAP: state_nxt = ST_FETCH;
      default: state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state     <= ST_RESET;
      cause     <= '0;
      trap_irq  <= 1'b0;
      alu_first <= 1'b0;
    end else begin
      state     <= state_nxt;
      cause     <= cause_nxt;
      trap_irq  <= trap_irq_nxt;
      alu_first <= (state == ST_DECODE);
    end
  end

  always_comb begin
    bus.O_decoder_en = 1'b0;
    bus.O_alu_en     = 1'b0;
    bus.O_bus_en     = 1'b0;
    bus.O_bus_sel    = 1'b0;
    bus.O_reg_we     = 1'b0;
    bus.O_pc_we      = 1'b0;
    bus.O_pc_sel     = PCSEL_INC;
    bus.O_trap       = 1'b0;
    bus.O_trap_irq   = 1'b0;
    bus.O_trap_cause = 4'd0;
    bus.O_state      = state;
    case (state)
      ST_FETCH: begin
        bus.O_bus_en     = 1'b1;
        bus.O_decoder_en = bus.I_bus_ack;
      end
      ST_EXEC: bus.O_alu_en = alu_first;
      ST_MEM: begin
        bus.O_bus_en  = 1'b1;
        bus.O_bus_sel = 1'b1;
      end
      ST_WB: begin
        bus.O_pc_we  = 1'b1;
        bus.O_reg_we = !(bus.I_opcode == OP_STORE || bus.I_opcode == OP_BRANCH ||
                         bus.I_opcode == OP_MISCMEM);
        if (bus.I_opcode == OP_JAL || bus.I_opcode == OP_JALR ||
            (bus.I_opcode == OP_BRANCH && bus.I_branch_taken))
          bus.O_pc_sel = PCSEL_TARGET;
      end
      ST_TRAP: begin
        bus.O_trap       = 1'b1;
        bus.O_pc_we      = 1'b1;
        bus.O_pc_sel     = PCSEL_TRAP;
        bus.O_trap_irq   = trap_irq;
        bus.O_trap_cause = cause;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spu32_cpu_sequencer.sv
// Randomized bench for spu32_cpu_sequencer: an instruction-level model
// expands each instruction into its expected per-cycle output word.
module tb_spu32_cpu_sequencer;

  localparam int TMO = 4;

  localparam logic [4:0] LOAD = 5'b00000, MISCMEM = 5'b00011, OPIMM = 5'b00100,
                         AUIPC = 5'b00101, STORE = 5'b01000, OPR = 5'b01100,
                         LUI = 5'b01101, BRANCH = 5'b11000, JALR = 5'b11001,
                         JAL = 5'b11011, SYSTEM = 5'b11100;

  localparam logic [2:0] S_RST = 3'd0, S_FET = 3'd1, S_DEC = 3'd2, S_EXE = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRP = 3'd6;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  spu32_cpu_sequencer_if dif ();

  spu32_cpu_sequencer #(.BUS_TIMEOUT(TMO)) dut (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .bus       (dif)
  );

  always #5 clk = ~clk;

  logic [16:0] word;
  assign word = {dif.O_state, dif.O_decoder_en, dif.O_alu_en, dif.O_bus_en, dif.O_bus_sel,
                 dif.O_reg_we, dif.O_pc_we, dif.O_pc_sel, dif.O_trap, dif.O_trap_irq,
                 dif.O_trap_cause};

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%b want=%b @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] mk(input logic [2:0] st, input logic dec, input logic alu,
                                     input logic be, input logic bs, input logic rwe,
                                     input logic pwe, input logic [1:0] ps, input logic tr,
                                     input logic ti, input logic [3:0] c);
    return {st, dec, alu, be, bs, rwe, pwe, ps, tr, ti, c};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [4:0] op);
    return op inside {LOAD, STORE, OPR, OPIMM, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM, MISCMEM};
  endfunction

  // one cycle: drive inputs just after the edge, check mid-cycle
  task automatic step(input string tag, input logic ack, input logic busy, input logic irq,
                      input logic [16:0] exp);
    dif.I_bus_ack  = ack;
    dif.I_alu_busy = busy;
    dif.I_irq      = irq;
    @(negedge clk);
    chk(tag, word, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic trap(input string tag, input logic ti, input logic [3:0] c);
    step(tag, rb(), rb(), rb(), mk(S_TRP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, ti, c));
  endtask

  // fd/md: un-acked cycles before the ack; >= TMO means the bus never answers
  task automatic run_instr(input logic [4:0] op, input int fd, input int bn, input int md,
                           input logic irq_wb, input logic taken);
    logic       got;
    logic       rwe;
    logic [1:0] ps;
    dif.I_opcode       = 5'($urandom);
    dif.I_branch_taken = taken;
    got = 1'b0;
    for (int i = 0; i < TMO && !got; i++) begin
      got = (i == fd);
      step("fetch", got, rb(), rb(), mk(S_FET, got, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0));
    end
    if (!got) begin
      trap("trap_ifetch", 1'b0, 4'd1);
      return;
    end
    dif.I_opcode = op;
    step("decode", rb(), rb(), rb(), mk(S_DEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0));
    if (!legal(op)) begin
      trap("trap_illegal", 1'b0, 4'd2);
      return;
    end
    for (int i = 0; i <= bn; i++)
      step("exec", rb(), i < bn, rb(), mk(S_EXE, 1'b0, i == 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0));
    if (op == LOAD || op == STORE) begin
      got = 1'b0;
      for (int i = 0; i < TMO && !got; i++) begin
        got = (i == md);
        step("mem", got, rb(), rb(), mk(S_MEM, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0));
      end
      if (!got) begin
        trap("trap_mem", 1'b0, (op == STORE) ? 4'd7 : 4'd5);
        return;
      end
    end
    rwe = !(op == STORE || op == BRANCH || op == MISCMEM);
    ps  = (op == JAL || op == JALR || (op == BRANCH && taken)) ? 2'd1 : 2'd0;
    step("wb", rb(), rb(), irq_wb, mk(S_WB, 1'b0, 1'b0, 1'b0, 1'b0, rwe, 1'b1, ps, 1'b0, 1'b0, 4'd0));
    if (irq_wb && dif.I_irq_en) trap("trap_irq", 1'b1, 4'd11);
  endtask

  logic [4:0] ops [14];

  initial begin
    ops = '{LOAD, STORE, OPR, OPIMM, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM, MISCMEM,
            5'b11111, 5'b00001, 5'b10100};
    rst_n              = 1'b0;
    dif.I_opcode       = '0;
    dif.I_bus_ack      = 1'b0;
    dif.I_alu_busy     = 1'b0;
    dif.I_branch_taken = 1'b0;
    dif.I_irq          = 1'b0;
    dif.I_irq_en       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dif.I_bus_ack = 1'b1;
    chk("reset", word, 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_release", word, 17'd0);
    @(posedge clk);
    #1;

    run_instr(OPIMM, 1, 0, 0, 1'b0, 1'b0);
    run_instr(LOAD, 0, 0, 2, 1'b0, 1'b0);
    run_instr(STORE, 0, 0, 2, 1'b0, 1'b0);
    run_instr(OPR, 0, 32, 0, 1'b0, 1'b0);
    run_instr(BRANCH, 0, 0, 0, 1'b0, 1'b1);
    run_instr(BRANCH, 0, 0, 0, 1'b0, 1'b0);
    run_instr(5'b11111, 0, 0, 0, 1'b0, 1'b0);
    run_instr(OPIMM, TMO, 0, 0, 1'b0, 1'b0);
    run_instr(OPIMM, TMO - 1, 0, 0, 1'b0, 1'b0);
    run_instr(LOAD, 0, 0, TMO, 1'b0, 1'b0);
    run_instr(STORE, 0, 0, TMO, 1'b0, 1'b0);
    run_instr(LOAD, 0, 0, TMO - 1, 1'b0, 1'b0);
    dif.I_irq_en = 1'b1;
    run_instr(OPIMM, 0, 1, 0, 1'b1, 1'b0);
    run_instr(JAL, 0, 0, 0, 1'b1, 1'b0);

    // abort a data access mid-flight
    dif.I_branch_taken = 1'b0;
    step("fetch_r", 1'b1, 1'b0, 1'b0, mk(S_FET, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0));
    dif.I_opcode = LOAD;
    step("decode_r", 1'b0, 1'b0, 1'b0, mk(S_DEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0));
    step("exec_r", 1'b0, 1'b0, 1'b0, mk(S_EXE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0));
    step("mem_r", 1'b0, 1'b0, 1'b0, mk(S_MEM, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_async", word, 17'd0);
    @(negedge clk);
    chk("reset_held", word, 17'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      dif.I_irq_en = rb();
      run_instr(ops[$urandom_range(0, 13)], $urandom_range(0, TMO), $urandom_range(0, 3),
                $urandom_range(0, TMO), rb(), rb());
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
